// File: rtl/param_nibble_serializer_if.sv
`default_nettype none
// =============================================================================
// Module   : param_nibble_serializer_if
// Brief    : Word-load and nibble-stream handshake bundle for the serializer.
// Revision : 1.0
// =============================================================================
interface param_nibble_serializer_if #(
    parameter int P_NBITS   = 4,
    parameter int P_WIDTH   = 32,
    parameter int C_OFFBITS = 3
);
    logic                 load_val;
    logic                 load_rdy;
    logic [P_WIDTH-1:0]   load_data;
    logic                 load_dir;
    logic                 flush;
    logic                 nib_val;
    logic                 nib_rdy;
    logic [P_NBITS-1:0]   nib_data;
    logic [C_OFFBITS-1:0] nib_idx;
    logic                 nib_first;
    logic                 nib_last;
    logic                 done;

    // Producer of words / consumer of nibbles
    modport master (
        output load_val, load_data, load_dir, flush, nib_rdy,
        input  load_rdy, nib_val, nib_data, nib_idx, nib_first, nib_last, done
    );

    // The serializer itself
    modport slave (
        input  load_val, load_data, load_dir, flush, nib_rdy,
        output load_rdy, nib_val, nib_data, nib_idx, nib_first, nib_last, done
    );
endinterface
`default_nettype wire

// File: rtl/param_nibble_serializer.sv
`default_nettype none
// =============================================================================
// Module   : param_nibble_serializer
// Brief    : 32-bit word to nibble-serial stream, LSB- or MSB-first per word.
// Revision : 1.0
// =============================================================================
module param_nibble_serializer #(
    parameter int P_NBITS   = 4,
    parameter int P_WIDTH   = 32,
    parameter int C_OFFBITS = 3
) (
    input  wire logic                  clk,
    input  wire logic                  reset_n,
    param_nibble_serializer_if.slave   bus
);

    localparam int                   C_N_OFF = P_WIDTH / P_NBITS;
    localparam logic [C_OFFBITS-1:0] C_LAST  = C_OFFBITS'(C_N_OFF - 1);

    generate
        if ((P_WIDTH % P_NBITS) != 0 || C_N_OFF < 2 || (1 << C_OFFBITS) < C_N_OFF) begin : g_param_check
            $error("param_nibble_serializer: illegal P_NBITS/P_WIDTH/C_OFFBITS combination");
        end
    endgenerate

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [P_WIDTH-1:0]   r_shreg, w_shreg_nxt;
    logic [C_OFFBITS-1:0] r_count, w_count_nxt;
    logic                 r_dir,   w_dir_nxt;
    logic                 r_done,  w_done_nxt;

    logic                 w_last;
    logic                 w_nib_val;
    logic                 w_load_rdy;
    logic                 w_load_acc;
    logic                 w_nib_acc;
    logic [P_WIDTH-1:0]   w_rot_right;
    logic [P_WIDTH-1:0]   w_rot_left;

    assign w_last     = (r_count == C_LAST);
    assign w_nib_val  = (r_state == ST_SHIFT);
    // Ready on the last accepted nibble lets the next word follow with no bubble
    assign w_load_rdy = !bus.flush &&
                        ((r_state == ST_IDLE) || ((r_state == ST_SHIFT) && bus.nib_rdy && w_last));
    assign w_load_acc = bus.load_val && w_load_rdy;
    assign w_nib_acc  = w_nib_val && bus.nib_rdy;

    assign w_rot_right = {r_shreg[P_NBITS-1:0], r_shreg[P_WIDTH-1:P_NBITS]};
    assign w_rot_left  = {r_shreg[P_WIDTH-P_NBITS-1:0], r_shreg[P_WIDTH-1:P_WIDTH-P_NBITS]};

    always_comb begin
        w_state_nxt = r_state;
        w_shreg_nxt = r_shreg;
        w_count_nxt = r_count;
        w_dir_nxt   = r_dir;
        w_done_nxt  = 1'b0;

        if (bus.flush) begin
            w_state_nxt = ST_IDLE;
            w_count_nxt = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_IDLE;
                end
                ST_SHIFT: begin
                    if (w_nib_acc) begin
                        // Rotating on every accept returns the word to its loaded value
                        w_shreg_nxt = r_dir ? w_rot_left : w_rot_right;
                        if (w_last) begin
                            w_done_nxt  = 1'b1;
                            w_state_nxt = ST_IDLE;
                            w_count_nxt = '0;
                        end else begin
                            w_count_nxt = r_count + C_OFFBITS'(1);
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_count_nxt = '0;
                end
            endcase

            if (w_load_acc) begin
                w_shreg_nxt = bus.load_data;
                w_dir_nxt   = bus.load_dir;
                w_count_nxt = '0;
                w_state_nxt = ST_SHIFT;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_shreg <= '0;
            r_count <= '0;
            r_dir   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_shreg <= w_shreg_nxt;
            r_count <= w_count_nxt;
            r_dir   <= w_dir_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign bus.load_rdy  = w_load_rdy;
    assign bus.nib_val   = w_nib_val;
    assign bus.nib_data  = r_dir ? r_shreg[P_WIDTH-1 -: P_NBITS] : r_shreg[P_NBITS-1:0];
    assign bus.nib_idx   = r_dir ? (C_LAST - r_count) : r_count;
    assign bus.nib_first = w_nib_val && (r_count == '0);
    assign bus.nib_last  = w_nib_val && w_last;
    assign bus.done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_param_nibble_serializer.sv
`default_nettype none
// =============================================================================
// Module   : tb_param_nibble_serializer
// Brief    : Self-checking bench for param_nibble_serializer.
// Revision : 1.0
// =============================================================================
module tb_param_nibble_serializer;

    localparam int NB   = 4;
    localparam int W    = 32;
    localparam int OB   = 3;
    localparam int NOFF = W / NB;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    param_nibble_serializer_if #(.P_NBITS(NB), .P_WIDTH(W), .C_OFFBITS(OB)) bus ();

    param_nibble_serializer #(.P_NBITS(NB), .P_WIDTH(W), .C_OFFBITS(OB)) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    logic          s_load_rdy, s_nib_val, s_first, s_last, s_done;
    logic [NB-1:0] s_nib_data;
    logic [OB-1:0] s_nib_idx;

    // Reference: nibble k of a word in stream order, from plain shifts
    function automatic logic [3:0] exp_nib(logic [31:0] w, bit d, int k);
        logic [31:0] t;
        int pos;
        pos = d ? (NOFF - 1 - k) : k;
        t   = w >> (NB * pos);
        return t[3:0];
    endfunction

    function automatic logic [2:0] exp_idx(bit d, int k);
        int i;
        i = d ? (NOFF - 1 - k) : k;
        return i[2:0];
    endfunction

    function automatic logic [11:0] mk(bit v, logic [3:0] d, logic [2:0] i, bit f, bit l, bit dn, bit lr);
        return {v, d, i, f, l, dn, lr};
    endfunction

    function automatic logic [4:0] mkc(bit v, bit f, bit l, bit dn, bit lr);
        return {v, f, l, dn, lr};
    endfunction

    function automatic logic [11:0] obs_full();
        return {s_nib_val, s_nib_data, s_nib_idx, s_first, s_last, s_done, s_load_rdy};
    endfunction

    function automatic logic [4:0] obs_ctl();
        return {s_nib_val, s_first, s_last, s_done, s_load_rdy};
    endfunction

    task automatic sample();
        s_load_rdy = bus.load_rdy;
        s_nib_val  = bus.nib_val;
        s_nib_data = bus.nib_data;
        s_nib_idx  = bus.nib_idx;
        s_first    = bus.nib_first;
        s_last     = bus.nib_last;
        s_done     = bus.done;
    endtask

    // Drive one cycle's inputs after the falling edge, then sample mid-cycle
    task automatic step(input bit lv, input logic [31:0] ld, input bit dr, input bit fl, input bit nr);
        @(negedge clk);
        bus.load_val  = lv;
        bus.load_data = ld;
        bus.load_dir  = dr;
        bus.flush     = fl;
        bus.nib_rdy   = nr;
        #1;
        sample();
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            step(0, 32'h0, 0, 0, 1);
            n_cmp++;
            if (obs_ctl() !== mkc(0, 0, 0, 0, 1)) begin
                n_fail++;
                $display("FAIL reset_hold[%0d]: got %b want %b (val,first,last,done,load_rdy)", c, obs_ctl(), mkc(0, 0, 0, 0, 1));
            end
        end
        reset_n = 1'b1;
        step(0, 32'h0, 0, 0, 1);
        n_cmp++;
        if (obs_ctl() !== mkc(0, 0, 0, 0, 1)) begin
            n_fail++;
            $display("FAIL reset_release: got %b want %b", obs_ctl(), mkc(0, 0, 0, 0, 1));
        end
    endtask

    task automatic test_single_word(input string nm, input logic [31:0] w, input bit d);
        step(1, w, d, 0, 1);
        n_cmp++;
        if (obs_ctl() !== mkc(0, 0, 0, 0, 1)) begin
            n_fail++;
            $display("FAIL %s_load: got %b want %b", nm, obs_ctl(), mkc(0, 0, 0, 0, 1));
        end
        for (int k = 0; k < NOFF; k++) begin
            logic [11:0] e;
            step(0, w, d, 0, 1);
            e = mk(1, exp_nib(w, d, k), exp_idx(d, k), k == 0, k == NOFF - 1, 0, k == NOFF - 1);
            n_cmp++;
            if (obs_full() !== e) begin
                n_fail++;
                $display("FAIL %s_nib[%0d]: got %b want %b (val,data,idx,first,last,done,load_rdy)", nm, k, obs_full(), e);
            end
        end
        step(0, w, d, 0, 1);
        n_cmp++;
        if (obs_ctl() !== mkc(0, 0, 0, 1, 1)) begin
            n_fail++;
            $display("FAIL %s_done: got %b want %b", nm, obs_ctl(), mkc(0, 0, 0, 1, 1));
        end
        step(0, w, d, 0, 1);
        n_cmp++;
        if (obs_ctl() !== mkc(0, 0, 0, 0, 1)) begin
            n_fail++;
            $display("FAIL %s_done_clear: got %b want %b", nm, obs_ctl(), mkc(0, 0, 0, 0, 1));
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ws [2];
        ws[0] = 32'h0000_0001;
        ws[1] = 32'h2000_0000;
        step(1, ws[0], 0, 0, 1);
        for (int g = 0; g < 2 * NOFF; g++) begin
            logic [11:0] e;
            int wi, k;
            wi = g / NOFF;
            k  = g % NOFF;
            step(g < NOFF, ws[1], 0, 0, 1);
            e = mk(1, exp_nib(ws[wi], 0, k), exp_idx(0, k), k == 0, k == NOFF - 1, g == NOFF, k == NOFF - 1);
            n_cmp++;
            if (obs_full() !== e) begin
                n_fail++;
                $display("FAIL b2b_nib[%0d]: got %b want %b", g, obs_full(), e);
            end
        end
        step(0, 32'h0, 0, 0, 1);
        n_cmp++;
        if (obs_ctl() !== mkc(0, 0, 0, 1, 1)) begin
            n_fail++;
            $display("FAIL b2b_done2: got %b want %b", obs_ctl(), mkc(0, 0, 0, 1, 1));
        end
        step(0, 32'h0, 0, 0, 1);
    endtask

    task automatic test_backpressure();
        logic [31:0] w;
        int k;
        w = 32'h1234_5678;
        k = 0;
        step(1, w, 0, 0, 1);
        for (int c = 0; c < NOFF + 3; c++) begin
            logic [11:0] e;
            bit nr;
            nr = !(c >= 2 && c <= 4);
            step(0, w, 0, 0, nr);
            e = mk(1, exp_nib(w, 0, k), exp_idx(0, k), k == 0, k == NOFF - 1, 0, nr && (k == NOFF - 1));
            n_cmp++;
            if (obs_full() !== e) begin
                n_fail++;
                $display("FAIL bp_cycle[%0d]: got %b want %b", c, obs_full(), e);
            end
            if (nr) k++;
        end
        step(0, w, 0, 0, 1);
        n_cmp++;
        if (obs_ctl() !== mkc(0, 0, 0, 1, 1)) begin
            n_fail++;
            $display("FAIL bp_done: got %b want %b", obs_ctl(), mkc(0, 0, 0, 1, 1));
        end
        step(0, w, 0, 0, 1);
    endtask

    task automatic test_flush();
        logic [31:0] w;
        logic [11:0] e;
        w = 32'h89AB_CDEF;
        step(1, w, 0, 0, 1);
        for (int k = 0; k < 3; k++) step(0, w, 0, 0, 1);
        step(1, 32'hFFFF_FFFF, 0, 1, 1);
        e = mk(1, exp_nib(w, 0, 3), exp_idx(0, 3), 0, 0, 0, 0);
        n_cmp++;
        if (obs_full() !== e) begin
            n_fail++;
            $display("FAIL flush_cycle: got %b want %b", obs_full(), e);
        end
        step(0, 32'h0, 0, 0, 1);
        n_cmp++;
        if (obs_ctl() !== mkc(0, 0, 0, 0, 1)) begin
            n_fail++;
            $display("FAIL flush_after: got %b want %b", obs_ctl(), mkc(0, 0, 0, 0, 1));
        end
        test_single_word("flush_reload", 32'hFFFF_FFFF, 0);
    endtask

    task automatic test_async_reset();
        logic [31:0] w;
        w = 32'h1357_9BDF;
        // Reset landing on a done cycle must clear done immediately
        step(1, w, 1, 0, 1);
        for (int k = 0; k < NOFF; k++) step(0, w, 1, 0, 1);
        step(0, w, 1, 0, 1);
        n_cmp++;
        if (s_done !== 1'b1) begin
            n_fail++;
            $display("FAIL areset_pre_done: got %b want 1", s_done);
        end
        #2 reset_n = 1'b0;
        #1 sample();
        n_cmp++;
        if (obs_ctl() !== mkc(0, 0, 0, 0, 1)) begin
            n_fail++;
            $display("FAIL areset_done_drop: got %b want %b", obs_ctl(), mkc(0, 0, 0, 0, 1));
        end
        @(negedge clk);
        #1 reset_n = 1'b1;
        // Reset in the middle of a word
        step(1, w, 1, 0, 1);
        for (int k = 0; k < 3; k++) step(0, w, 1, 0, 1);
        step(0, w, 1, 0, 0);
        n_cmp++;
        if (obs_full() !== mk(1, exp_nib(w, 1, 3), exp_idx(1, 3), 0, 0, 0, 0)) begin
            n_fail++;
            $display("FAIL areset_pre_mid: got %b want %b", obs_full(), mk(1, exp_nib(w, 1, 3), exp_idx(1, 3), 0, 0, 0, 0));
        end
        #2 reset_n = 1'b0;
        #1 sample();
        n_cmp++;
        if (obs_ctl() !== mkc(0, 0, 0, 0, 1)) begin
            n_fail++;
            $display("FAIL areset_mid_drop: got %b want %b", obs_ctl(), mkc(0, 0, 0, 0, 1));
        end
        @(negedge clk);
        #1 reset_n = 1'b1;
        test_single_word("after_reset", 32'hA5A5_A5A5, 0);
    endtask

    task automatic test_random();
        bit          active, cd, e_done, pend, pd;
        logic [31:0] cw, pw;
        int          k;
        active = 0; cd = 0; e_done = 0; pend = 0; pd = 0; cw = '0; pw = '0; k = 0;
        for (int c = 0; c < 400; c++) begin
            bit fl, nr, e_lr, nd;
            if (!pend && $urandom_range(0, 2) != 0) begin
                pend = 1;
                pw   = $urandom;
                pd   = 1'($urandom_range(0, 1));
            end
            fl = ($urandom_range(0, 24) == 0);
            nr = ($urandom_range(0, 3) != 0);
            step(pend, pw, pd, fl, nr);
            e_lr = !fl && (!active || (nr && k == NOFF - 1));
            n_cmp++;
            if (active) begin
                logic [11:0] e;
                e = mk(1, exp_nib(cw, cd, k), exp_idx(cd, k), k == 0, k == NOFF - 1, e_done, e_lr);
                if (obs_full() !== e) begin
                    n_fail++;
                    $display("FAIL rand_active[%0d]: got %b want %b", c, obs_full(), e);
                end
            end else if (obs_ctl() !== mkc(0, 0, 0, e_done, e_lr)) begin
                n_fail++;
                $display("FAIL rand_idle[%0d]: got %b want %b", c, obs_ctl(), mkc(0, 0, 0, e_done, e_lr));
            end
            nd = 0;
            if (fl) begin
                active = 0;
                k      = 0;
            end else begin
                if (active && nr) begin
                    if (k == NOFF - 1) begin
                        active = 0;
                        nd     = 1;
                    end else begin
                        k++;
                    end
                end
                if (pend && e_lr) begin
                    active = 1;
                    cw     = pw;
                    cd     = pd;
                    k      = 0;
                    pend   = 0;
                end
            end
            e_done = nd;
        end
    endtask

    initial begin
        bus.load_val  = 1'b0;
        bus.load_data = '0;
        bus.load_dir  = 1'b0;
        bus.flush     = 1'b0;
        bus.nib_rdy   = 1'b1;
        test_reset();
        test_single_word("lsb_first", 32'h89AB_CDEF, 0);
        test_single_word("msb_first", 32'h89AB_CDEF, 1);
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/param_nibble_serializer.md
Name: param_nibble_serializer

Overview:
- Parallel-to-nibble-serial converter for the bit-serial datapath: accepts a 32-bit word and emits it as 8 nibbles on a valid/ready stream toward the nibble ALU input.
- Counterpart of the address deserializing register: it produces the nibble streams that register consumes.
- Used for register-file operands and immediates; direction is selectable per word (LSB-first for arithmetic, MSB-first for compare/shift-style uops).

Parameters:
- P_NBITS, 4, nibble width in bits.
- P_WIDTH, 32, word width; must be a multiple of P_NBITS.
- C_N_OFF, P_WIDTH/P_NBITS (8), nibbles per word; derived, not overridable.
- C_OFFBITS, 3, width of the nibble index; must satisfy 2^C_OFFBITS >= C_N_OFF.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- load_val  in  1  parallel word offered.
- load_rdy  out  1  serializer can accept a word this cycle.
- load_data  in  P_WIDTH  word to serialize.
- load_dir  in  1  0 = LSB nibble first, 1 = MSB nibble first; sampled on load.
- flush  in  1  abort the current word (squash or redirect).
- nib_val  out  1  nibble valid.
- nib_rdy  in  1  consumer accepts the nibble.
- nib_data  out  P_NBITS  current nibble.
- nib_idx  out  C_OFFBITS  position of the nibble within the word (0 = bits [3:0]).
- nib_first  out  1  first nibble of the word.
- nib_last  out  1  final nibble of the word.
- done  out  1  one-cycle pulse, the cycle after the last nibble is accepted.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - State is IDLE; shift register = 0; count = 0; dir = 0; done = 0.
  - nib_val = 0 and load_rdy = 1 while in reset.
- States:
  - IDLE: nib_val=0.
  - SHIFT: nib_val=1.
- Handshakes:
  - A load is accepted when load_val && load_rdy && !flush.
  - A nibble is accepted when nib_val && nib_rdy.
- load_rdy = !flush && (IDLE || (SHIFT && nib_rdy && count==C_N_OFF-1)). This is combinational, so back-to-back words run with zero bubbles.
- Load:
  - On acceptance, the shift register takes load_data, dir takes load_dir, count goes to 0, and the state goes to SHIFT.
  - The first nibble is presented in the next cycle (latency 1).
- Nibble output:
  - dir=0: nib_data = shreg[P_NBITS-1:0]; on each accepted nibble, rotate right by P_NBITS.
  - dir=1: nib_data = shreg[P_WIDTH-1:P_WIDTH-P_NBITS]; on each accepted nibble, rotate left by P_NBITS.
  - After 8 accepts the register has rotated a full turn and holds its original value again.
  - nib_idx = count when dir=0; (C_N_OFF-1-count) when dir=1.
  - nib_first = (count==0); nib_last = (count==C_N_OFF-1); both are qualified by nib_val.
- Backpressure: with nib_rdy=0 and SHIFT, every output holds steady and nothing changes.
- Accepted nibble while count<7: count increments.
- Accepted nibble while count==7:
  - done=1 in the next cycle.
  - If a load is accepted in the same cycle, the new word is loaded and the state stays SHIFT.
  - Otherwise the state goes to IDLE.
- Flush:
  - Takes priority over load and nibble acceptance.
  - Next cycle: state IDLE, count 0, nib_val 0, done 0. The shift register contents are don't-care.
  - load_rdy=0 while flush=1.
- done is never asserted together with an aborted word.
- load_val while SHIFT and not on the last accepted nibble: ignored (load_rdy=0). The producer holds load_val.

Test Plan:
- Load 0x89ABCDEF with dir=0, nib_rdy=1 constantly.
  - nib_data is F,E,D,C,B,A,9,8 on cycles 1..8; nib_idx is 0..7.
  - nib_first on cycle 1, nib_last on cycle 8; done on cycle 9; load_rdy=1 again on cycle 8.
- Same word with dir=1.
  - nib_data is 8,9,A,B,C,D,E,F; nib_idx is 7..0.
- Back-to-back: load 0x00000001 then 0x20000000 (dir=0) with load_val held high.
  - 16 consecutive valid nibbles with no gap: 1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,2.
  - done pulses after nibble 8 and after nibble 16.
- Backpressure: load 0x12345678 (dir=0); drop nib_rdy for 3 cycles after the 2nd nibble.
  - nib_data=6 and nib_idx=2 are held stable for 3 cycles; the full sequence 8,7,6,5,4,3,2,1 completes.
- Flush after the 3rd accepted nibble with load_val=1 in the same cycle.
  - Next cycle: nib_val=0, load not accepted, done stays 0.
  - A following load of 0xFFFFFFFF streams F x8 with nib_first on its first nibble.
- Assert reset_n=0 asynchronously mid-word, between clock edges.
  - nib_val and done drop immediately and load_rdy=1.
  - After release, the bench loads 0xA5A5A5A5 (dir=0) and sees 5,A,5,A,5,A,5,A.
